// File: rtl/hcsr04_emulador.sv
// hcsr04_emulador: HC-SR04 responder, trigger in, echo out.
// Echo width encodes a programmed 3-digit BCD distance.
module hcsr04_emulador #(
  parameter int TRIG_MIN = 500,
  parameter int R        = 2941,
  parameter int ATRASO   = 10000,
  parameter int HOLDOFF  = 500,
  parameter int MAX_CM   = 400
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger,
  input  logic [11:0] distancia,
  output logic        echo,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro,
  output logic [2:0]  db_estado
);

  localparam int MAXW = MAX_CM * R;
  localparam int MA   = (MAXW > ATRASO) ? MAXW : ATRASO;
  localparam int MB   = (MA > HOLDOFF) ? MA : HOLDOFF;
  localparam int MC   = (MB > TRIG_MIN) ? MB : TRIG_MIN;
  localparam int CW   = $clog2(MC + 1);

  localparam logic [CW-1:0] UM = CW'(1);

  typedef enum logic [2:0] {
    E_INICIAL       = 3'd0,
    E_TRIG_ALTO     = 3'd1,
    E_ATRASO        = 3'd2,
    E_ECO           = 3'd3,
    E_RECUPERA      = 3'd4,
    E_AGUARDA_BAIXO = 3'd5
  } estado_t;

  estado_t       r_estado, w_prox;
  logic          r_sync1, r_trig_s, r_trig_ant;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [9:0]    r_dist, w_dist;
  logic          r_pronto, w_pronto;
  logic          r_erro, w_erro;

  logic          w_borda;
  logic          w_bcd_ok;
  logic [9:0]    w_dec;
  logic [9:0]    w_dec_sat;
  logic [CW-1:0] w_largura;

  assign w_borda = r_trig_s & ~r_trig_ant;

  assign w_bcd_ok = (distancia[11:8] <= 4'd9) &&
                    (distancia[7:4]  <= 4'd9) &&
                    (distancia[3:0]  <= 4'd9);

  assign w_dec = ({6'd0, distancia[11:8]} * 10'd100) +
                 ({6'd0, distancia[7:4]}  * 10'd10) +
                  {6'd0, distancia[3:0]};

  // Zero is reported as 1 cm; far targets saturate at the sensor range.
  always_comb begin
    w_dec_sat = w_dec;
    if (w_dec == 10'd0)
      w_dec_sat = 10'd1;
    else if (w_dec > 10'(MAX_CM))
      w_dec_sat = 10'(MAX_CM);
  end

  assign w_largura = CW'(r_dist) * CW'(R);

  // Two-flop synchroniser plus previous-value flop for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b0;
      r_trig_s   <= 1'b0;
      r_trig_ant <= 1'b0;
    end else begin
      r_sync1    <= trigger;
      r_trig_s   <= r_sync1;
      r_trig_ant <= r_trig_s;
    end
  end

  // State, shared counter, latched distance and strobe registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= E_INICIAL;
      r_cnt    <= '0;
      r_dist   <= 10'd1;
      r_pronto <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_cnt    <= w_cnt;
      r_dist   <= w_dist;
      r_pronto <= w_pronto;
      r_erro   <= w_erro;
    end
  end

  // Next-state, counter and strobe decisions.
  always_comb begin
    w_prox   = r_estado;
    w_cnt    = r_cnt;
    w_dist   = r_dist;
    w_pronto = 1'b0;
    w_erro   = 1'b0;
    unique case (r_estado)
      E_INICIAL: begin
        // The edge clock is already one clock of trigger width.
        if (w_borda) begin
          w_prox = E_TRIG_ALTO;
          w_cnt  = UM;
        end
      end
      E_TRIG_ALTO: begin
        if (r_trig_s) begin
          if (r_cnt < CW'(TRIG_MIN))
            w_cnt = r_cnt + UM;
        end else if (r_cnt < CW'(TRIG_MIN)) begin
          w_erro = 1'b1;
          w_prox = E_INICIAL;
        end else if (!w_bcd_ok) begin
          w_erro = 1'b1;
          w_prox = E_RECUPERA;
          w_cnt  = '0;
        end else begin
          w_dist = w_dec_sat;
          w_prox = E_ATRASO;
          w_cnt  = '0;
        end
      end
      E_ATRASO: begin
        if (r_cnt == CW'(ATRASO - 1)) begin
          w_prox = E_ECO;
          w_cnt  = '0;
        end else begin
          w_cnt = r_cnt + UM;
        end
      end
      E_ECO: begin
        if (r_cnt == w_largura - UM) begin
          w_prox   = E_RECUPERA;
          w_cnt    = '0;
          w_pronto = 1'b1;
        end else begin
          w_cnt = r_cnt + UM;
        end
      end
      E_RECUPERA: begin
        if (r_cnt == CW'(HOLDOFF - 1)) begin
          w_cnt  = '0;
          w_prox = r_trig_s ? E_AGUARDA_BAIXO : E_INICIAL;
        end else begin
          w_cnt = r_cnt + UM;
        end
      end
      E_AGUARDA_BAIXO: begin
        if (!r_trig_s)
          w_prox = E_INICIAL;
      end
      default: begin
        w_prox = E_INICIAL;
        w_cnt  = '0;
      end
    endcase
  end

  assign echo      = (r_estado == E_ECO);
  assign ocupado   = (r_estado == E_ATRASO) ||
                     (r_estado == E_ECO) ||
                     (r_estado == E_RECUPERA);
  assign pronto    = r_pronto;
  assign erro      = r_erro;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// tb_hcsr04_emulador: directed bench for the HC-SR04 emulator.
// Small timing parameters keep runs short.
module tb_hcsr04_emulador;

  localparam int TMIN = 5;
  localparam int RR   = 7;
  localparam int ATR  = 20;
  localparam int HOLD = 6;
  localparam int MAXC = 400;
  localparam int LAT  = ATR + 3;

  logic        clk;
  logic        rst_n;
  logic        trigger;
  logic [11:0] distancia;
  logic        echo;
  logic        ocupado;
  logic        pronto;
  logic        erro;
  logic [2:0]  db_estado;

  int n_vec;
  int n_err;

  hcsr04_emulador #(
    .TRIG_MIN (TMIN),
    .R        (RR),
    .ATRASO   (ATR),
    .HOLDOFF  (HOLD),
    .MAX_CM   (MAXC)
  ) dut (
    .clock     (clk),
    .reset     (rst_n),
    .trigger   (trigger),
    .distancia (distancia),
    .echo      (echo),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulso(input int w);
    @(negedge clk);
    trigger = 1'b1;
    repeat (w) @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic esperar_eco(output int lat);
    lat = -1;
    for (int i = 1; i <= ATR + 40; i++) begin
      @(negedge clk);
      if (echo === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic medir(output int lat, output int wid,
                       output int prn, output int hold);
    wid  = 0;
    prn  = 0;
    hold = 0;
    esperar_eco(lat);
    if (lat < 0) return;
    while (echo === 1'b1 && wid < 5000) begin
      wid++;
      @(negedge clk);
    end
    while (ocupado === 1'b1 && hold < 100) begin
      if (pronto === 1'b1) prn++;
      hold++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [6:0] got;
    rst_n     = 1'b0;
    trigger   = 1'b0;
    distancia = 12'h025;
    repeat (3) @(negedge clk);
    got = {echo, ocupado, pronto, erro, db_estado};
    n_vec++;
    if (got !== 7'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected %b", got, 7'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL idle_state: got %0d expected 0", db_estado);
    end
  endtask

  task automatic test_valid_echo;
    int lat, wid, prn, hold;
    distancia = 12'h025;
    pulso(TMIN);
    medir(lat, wid, prn, hold);
    n_vec++;
    if (lat !== LAT) begin
      n_err++;
      $display("FAIL echo_latency: got %0d expected %0d", lat, LAT);
    end
    n_vec++;
    if (wid !== 25 * RR) begin
      n_err++;
      $display("FAIL echo_width_25: got %0d expected %0d", wid, 25 * RR);
    end
    n_vec++;
    if (prn !== 1) begin
      n_err++;
      $display("FAIL pronto_pulse: got %0d expected 1", prn);
    end
    n_vec++;
    if (hold !== HOLD) begin
      n_err++;
      $display("FAIL holdoff_ocupado: got %0d expected %0d", hold, HOLD);
    end
    n_vec++;
    if (db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL back_to_idle: got %0d expected 0", db_estado);
    end
  endtask

  task automatic test_short_trigger;
    int widths [2] = '{3, TMIN - 1};
    for (int k = 0; k < 2; k++) begin
      int ne, nh;
      ne = 0;
      nh = 0;
      distancia = 12'h025;
      pulso(widths[k]);
      repeat (30) begin
        @(negedge clk);
        if (erro === 1'b1) ne++;
        if (echo === 1'b1) nh++;
      end
      n_vec++;
      if (ne !== 1 || nh !== 0 || db_estado !== 3'd0) begin
        n_err++;
        $display("FAIL short_trig_w%0d: erro %0d echo %0d st %0d expected 1 0 0",
                 widths[k], ne, nh, db_estado);
      end
    end
  endtask

  task automatic test_bcd_invalid;
    int ne, nh, no;
    ne = 0;
    nh = 0;
    no = 0;
    distancia = 12'h0A5;
    pulso(TMIN);
    repeat (ATR + 40) begin
      @(negedge clk);
      if (erro === 1'b1) ne++;
      if (echo === 1'b1) nh++;
      if (ocupado === 1'b1) no++;
    end
    n_vec++;
    if (ne !== 1 || nh !== 0) begin
      n_err++;
      $display("FAIL bcd_invalid: erro %0d echo %0d expected 1 0", ne, nh);
    end
    n_vec++;
    if (no !== HOLD) begin
      n_err++;
      $display("FAIL bcd_ocupado: got %0d expected %0d", no, HOLD);
    end
  endtask

  task automatic test_clamp;
    logic [11:0] dv [5] = '{12'h999, 12'h000, 12'h400, 12'h401, 12'h001};
    int          ev [5] = '{MAXC * RR, RR, MAXC * RR, MAXC * RR, RR};
    for (int k = 0; k < 5; k++) begin
      int lat, wid, prn, hold;
      distancia = dv[k];
      pulso(TMIN);
      medir(lat, wid, prn, hold);
      n_vec++;
      if (wid !== ev[k]) begin
        n_err++;
        $display("FAIL clamp_%h: got %0d expected %0d", dv[k], wid, ev[k]);
      end
    end
  endtask

  task automatic test_ignore;
    int lat, wid, nh;
    wid = 0;
    nh  = 0;
    distancia = 12'h025;
    pulso(TMIN);
    esperar_eco(lat);
    while (echo === 1'b1 && wid < 5000) begin
      if (wid == 20) trigger = 1'b1;
      if (wid == 20 + TMIN) trigger = 1'b0;
      if (wid == 30) distancia = 12'h100;
      wid++;
      @(negedge clk);
    end
    n_vec++;
    if (wid !== 25 * RR) begin
      n_err++;
      $display("FAIL ignore_width: got %0d expected %0d", wid, 25 * RR);
    end
    repeat (ATR + HOLD + 40) begin
      @(negedge clk);
      if (echo === 1'b1) nh++;
    end
    n_vec++;
    if (nh !== 0) begin
      n_err++;
      $display("FAIL ignore_no_echo: got %0d expected 0", nh);
    end
    distancia = 12'h025;
  endtask

  task automatic test_held_high;
    int lat, wid, prn, hold, nh;
    wid = 0;
    nh  = 0;
    distancia = 12'h025;
    pulso(TMIN);
    esperar_eco(lat);
    while (echo === 1'b1 && wid < 5000) begin
      if (wid == 50) trigger = 1'b1;
      wid++;
      @(negedge clk);
    end
    repeat (HOLD + ATR + 20) begin
      @(negedge clk);
      if (echo === 1'b1) nh++;
    end
    n_vec++;
    if (db_estado !== 3'd5 || nh !== 0) begin
      n_err++;
      $display("FAIL held_wait: st %0d echo %0d expected 5 0", db_estado, nh);
    end
    trigger = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (db_estado !== 3'd0) begin
      n_err++;
      $display("FAIL held_release: got %0d expected 0", db_estado);
    end
    pulso(TMIN);
    medir(lat, wid, prn, hold);
    n_vec++;
    if (wid !== 25 * RR) begin
      n_err++;
      $display("FAIL held_rearm: got %0d expected %0d", wid, 25 * RR);
    end
  endtask

  task automatic test_reset_mid_echo;
    int lat, wid, prn, hold;
    logic [4:0] got;
    distancia = 12'h025;
    pulso(TMIN);
    esperar_eco(lat);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {echo, ocupado, db_estado};
    n_vec++;
    if (got !== 5'd0) begin
      n_err++;
      $display("FAIL async_reset: got %b expected %b", got, 5'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulso(TMIN);
    medir(lat, wid, prn, hold);
    n_vec++;
    if (lat !== LAT || wid !== 25 * RR) begin
      n_err++;
      $display("FAIL post_reset: lat %0d wid %0d expected %0d %0d",
               lat, wid, LAT, 25 * RR);
    end
  endtask

  task automatic test_closed_loop;
    int lat, wid, prn, hold, cm;
    logic [11:0] bcd;
    distancia = 12'h123;
    pulso(TMIN);
    medir(lat, wid, prn, hold);
    cm  = wid / RR;
    bcd = {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    n_vec++;
    if (bcd !== 12'h123 || (wid % RR) != 0) begin
      n_err++;
      $display("FAIL closed_loop: got %h (wid %0d) expected 123", bcd, wid);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_valid_echo();
    test_short_trigger();
    test_bcd_invalid();
    test_clamp();
    test_ignore();
    test_held_high();
    test_reset_mid_echo();
    test_closed_loop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hcsr04_emulador.md
# hcsr04_emulador

Behavioural-synthesisable emulator of the HC-SR04 ultrasonic sensor: the responder end of the trigger/echo protocol driven by the sonar's sensor interface. It accepts a trigger pulse and, after a fixed burst delay, returns an echo pulse whose width encodes a programmed distance in the same 3-digit BCD format the interface produces. It is used on the FPGA board and in benches to exercise the interface and the sonar without a physical sensor.

## Interface
- TRIG_MIN, 500: minimum valid trigger width in clocks (10 us at 50 MHz)
- R, 2941: clocks per cm of echo width (58.82 us round trip)
- ATRASO, 10000: burst delay, trigger fall to echo rise, in clocks (200 us)
- HOLDOFF, 500: dead time after echo fall, in clocks; triggers are ignored during it
- MAX_CM, 400: saturation distance in cm
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low; clears all state and outputs
- trigger  in  1  trigger from interface; asynchronous to the emulator, synchronised internally
- distancia  in  12  programmed distance, BCD [11:8] hundreds, [7:4] tens, [3:0] units
- echo  out  1  echo pulse to interface
- ocupado  out  1  high from accepted trigger fall until end of HOLDOFF
- pronto  out  1  one-clock pulse after echo falls
- erro  out  1  one-clock pulse: short trigger or invalid BCD
- db_estado  out  3  current state code, for debug display

## Operation
- trigger passes a 2-FF synchroniser; all protocol decisions use the synchronised value (trig_s).
- States and codes: INICIAL 0, TRIG_ALTO 1, ATRASO 2, ECO 3, RECUPERA 4, AGUARDA_BAIXO 5.
- INICIAL: on trig_s rising edge (low to high) -> TRIG_ALTO, width counter cleared. Level-high without a seen low is not an edge.
- TRIG_ALTO: counts clocks with trig_s high. On trig_s low: count >= TRIG_MIN -> latch distancia, go ATRASO; otherwise erro pulse, go INICIAL. Trigger held high indefinitely: stays in TRIG_ALTO, counter saturates (no wrap).
- Latched distance check: any digit > 9 -> erro pulse, no echo, go RECUPERA. Value > MAX_CM -> echo width saturates to MAX_CM*R. Value 0 -> treated as 1 cm.
- ATRASO: wait exactly ATRASO clocks -> ECO.
- ECO: echo high for exactly D*R clocks (D = latched decimal value after clamp) -> RECUPERA, pronto pulse.
- RECUPERA: HOLDOFF clocks -> INICIAL if trig_s low, else AGUARDA_BAIXO.
- AGUARDA_BAIXO: wait for trig_s low -> INICIAL.
- Any trigger activity in ATRASO, ECO, RECUPERA ignored; distancia changes after latch have no effect on the current echo.
- ocupado = state in {ATRASO, ECO, RECUPERA}.

## Timing
- Reset values: echo 0, ocupado 0, pronto 0, erro 0, db_estado 0, synchroniser 0; reset asserted mid-echo drops echo immediately (asynchronous).
- Synchroniser latency: 2 clocks on both trigger edges; measured width equals raw width (both edges delayed equally).
- Echo rises ATRASO clocks after the clock edge on which trig_s is first sampled low in TRIG_ALTO.
- Echo width exactly D*R clocks; no jitter, no gaps.
- pronto and erro registered, high exactly one clock; pronto in the clock after echo falls.
- Minimum cycle between accepted triggers: TRIG_MIN + ATRASO + D*R + HOLDOFF + synchroniser latency.
- Counters sized for MAX_CM*R (1,176,400 at defaults, 21 bits); no overflow at any input.

## Test plan
- distancia=0x025, trigger high 500 clocks -> echo rises 10000 clocks after fall, high 73525 clocks, pronto 1 clock later, ocupado low after 500 more.
- Trigger high 300 clocks -> erro one-clock pulse, echo stays 0, db_estado returns 0.
- distancia=0x0A5, valid trigger -> erro pulse, no echo, ocupado high for HOLDOFF; distancia=0x999 -> echo width 1,176,400 clocks; distancia=0x000 -> 2941 clocks.
- Second trigger pulse during ECO, distancia changed to 0x100 mid-echo -> first echo width unchanged, no second echo; trigger held high through RECUPERA -> no echo until low then new rising edge.
- reset low at echo cycle 1000 -> echo, ocupado 0 immediately; after release a new valid trigger yields a correct full echo.
- Closed loop with sensor interface, distancia=0x123 -> interface reports 0x123.
